// File: rtl/packet_gen.sv
// Synthetic metadata source feeding one ingress VOQ stage: emits pkt_count words
// at a fixed spacing with fixed, round-robin or LFSR-chosen destination ports.
module packet_gen #(
  parameter logic [1:0]  SRC_ID     = 2'd0,
  parameter int          META_WIDTH = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  experimenting_i,
  input  logic                  cfg_we_i,
  input  logic [1:0]            cfg_addr_i,
  input  logic [15:0]           cfg_data_i,
  input  logic [15:0]           global_time_i,
  output logic [META_WIDTH-1:0] ingress_in_o,
  output logic                  ingress_in_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           sent_cnt_o
);

  // state  | meaning
  // S_IDLE | configurable, waiting for a rising edge of experimenting
  // S_EMIT | one word presented to ingress this cycle
  // S_WAIT | spacing countdown between two words
  // S_DONE | run finished, held until experimenting falls
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        exp_prev_q;
  logic [15:0] pkt_count_q;
  logic [15:0] interval_q;
  logic [1:0]  mode_q;
  logic [1:0]  fixed_dest_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [11:0] seq_q;
  logic [1:0]  rr_q;
  logic [15:0] sent_cnt_q;
  logic [15:0] wait_cnt_q;
  logic        en_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] interval_eff;
  logic        start_edge;
  logic        last_pkt;
  logic [1:0]  dest;

  assign interval_eff = (interval_q == 16'd0) ? 16'd1 : interval_q;
  assign start_edge   = experimenting_i & ~exp_prev_q;
  assign last_pkt     = ((sent_cnt_q + 16'd1) == pkt_count_q);

  // Fibonacci LFSR, taps 16,14,13,11
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    dest = fixed_dest_q;
    case (mode_q)
      2'd1:    dest = rr_q;
      2'd2:    dest = lfsr_q[1:0];
      default: dest = fixed_dest_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = (pkt_count_q != 16'd0) ? S_EMIT : S_DONE;
      end
      S_EMIT: begin
        if (!experimenting_i)          state_d = S_IDLE;
        else if (last_pkt)             state_d = S_DONE;
        else if (interval_eff == 16'd1) state_d = S_EMIT;
        else                           state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!experimenting_i)         state_d = S_IDLE;
        else if (wait_cnt_q == 16'd0) state_d = S_EMIT;
      end
      S_DONE: begin
        if (!experimenting_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      exp_prev_q   <= 1'b0;
      pkt_count_q  <= 16'd0;
      interval_q   <= 16'd1;
      mode_q       <= 2'd0;
      fixed_dest_q <= 2'd0;
      lfsr_q       <= LFSR_SEED;
      seq_q        <= 12'd0;
      rr_q         <= 2'd0;
      sent_cnt_q   <= 16'd0;
      wait_cnt_q   <= 16'd0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_prev_q <= experimenting_i;
      en_q       <= (state_d == S_EMIT);
      busy_q     <= (state_d == S_EMIT) || (state_d == S_WAIT);
      done_q     <= (state_d == S_DONE);

      if (cfg_we_i && (state_q == S_IDLE)) begin
        case (cfg_addr_i)
          2'd0: pkt_count_q <= cfg_data_i;
          2'd1: interval_q  <= cfg_data_i;
          2'd2: begin
            mode_q       <= cfg_data_i[1:0];
            fixed_dest_q <= cfg_data_i[3:2];
          end
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (start_edge && (pkt_count_q != 16'd0)) begin
            sent_cnt_q <= 16'd0;
            seq_q      <= 12'd0;
            lfsr_q     <= LFSR_SEED;
            rr_q       <= 2'd0;
          end
        end
        // An EMIT cycle that coincides with an abort still presented its word,
        // so it is counted like any other.
        S_EMIT: begin
          sent_cnt_q <= sent_cnt_q + 16'd1;
          seq_q      <= seq_q + 12'd1;
          rr_q       <= rr_q + 2'd1;
          lfsr_q     <= lfsr_d;
          wait_cnt_q <= interval_eff - 16'd2;
        end
        S_WAIT: begin
          if (wait_cnt_q != 16'd0) wait_cnt_q <= wait_cnt_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Timestamp is taken live so it reflects the emitting cycle itself.
  assign ingress_in_o    = en_q ? {SRC_ID, dest, seq_q, global_time_i} : '0;
  assign ingress_in_en_o = en_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign sent_cnt_o      = sent_cnt_q;

endmodule

// File: tb/tb_packet_gen.sv
// Directed bench for packet_gen: table of runs with hand-computed destination
// sequences, plus reset, abort, zero-count and sequence-wrap corner cases.
module tb_packet_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        experimenting;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [15:0] global_time = 16'h0100;
  logic [31:0] ingress_in;
  logic        ingress_in_en;
  logic        busy;
  logic        done;
  logic [15:0] sent_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cnt;
    int          intv;
    logic [1:0]  mode;
    logic [1:0]  fdest;
    int          spacing;
    logic [15:0] dests;   // dest of pulse i at [2*(i%8)+:2]
    bit          poke;    // write interval=1 while busy
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) global_time <= global_time + 16'h0013;

  packet_gen #(.SRC_ID(2'd1), .META_WIDTH(32), .LFSR_SEED(16'hACE1)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .experimenting_i (experimenting),
    .cfg_we_i        (cfg_we),
    .cfg_addr_i      (cfg_addr),
    .cfg_data_i      (cfg_data),
    .global_time_i   (global_time),
    .ingress_in_o    (ingress_in),
    .ingress_in_en_o (ingress_in_en),
    .busy_o          (busy),
    .done_o          (done),
    .sent_cnt_o      (sent_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int pulses;
    int last;
    int cyc;
    int budget;
    logic [1:0] ed;
    pulses = 0;
    last   = 0;
    cyc    = 0;
    budget = v.cnt * v.spacing + 20;
    cfg_write(2'd0, v.cnt[15:0]);
    cfg_write(2'd1, v.intv[15:0]);
    cfg_write(2'd2, {12'd0, v.fdest, v.mode});
    experimenting = 1'b1;
    while (done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
      cfg_we = 1'b0;
      if (ingress_in_en === 1'b1) begin
        ed = v.dests[2*(pulses%8) +: 2];
        if (pulses == 0) check({nm, " first_latency"}, cyc, 1);
        else             check({nm, " spacing"}, cyc - last, v.spacing);
        check({nm, " src"},  ingress_in[31:30], 2'd1);
        check({nm, " dest"}, ingress_in[29:28], ed);
        check({nm, " seq"},  ingress_in[27:16], pulses % 4096);
        check({nm, " time"}, ingress_in[15:0], global_time);
        check({nm, " busy"}, busy, 1'b1);
        pulses++;
        last = cyc;
        if (v.poke && pulses == 1) begin
          cfg_we   = 1'b1;
          cfg_addr = 2'd1;
          cfg_data = 16'd1;
        end
      end
    end
    cfg_we = 1'b0;
    check({nm, " done"},     done, 1'b1);
    check({nm, " pulses"},   pulses, v.cnt);
    check({nm, " sent_cnt"}, sent_cnt, v.cnt[15:0]);
    check({nm, " busy_end"}, busy, 1'b0);
    experimenting = 1'b0;
    tick();
    check({nm, " done_clear"}, done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses;
    int   cyc;
    int   extra;
    vec_t w;

    vecs[0] = '{cnt:4, intv:1, mode:2'd0, fdest:2'd2, spacing:1, dests:16'hAAAA, poke:1'b0};
    vecs[1] = '{cnt:8, intv:1, mode:2'd2, fdest:2'd0, spacing:1, dests:16'h92FD, poke:1'b0};
    vecs[2] = '{cnt:3, intv:5, mode:2'd1, fdest:2'd0, spacing:5, dests:16'h0024, poke:1'b1};
    vecs[3] = '{cnt:8, intv:1, mode:2'd2, fdest:2'd3, spacing:1, dests:16'h92FD, poke:1'b0};
    vecs[4] = '{cnt:2, intv:0, mode:2'd3, fdest:2'd1, spacing:1, dests:16'h0005, poke:1'b0};
    vecs[5] = '{cnt:3, intv:2, mode:2'd1, fdest:2'd2, spacing:2, dests:16'h0024, poke:1'b0};

    rst_n         = 1'b0;
    experimenting = 1'b0;
    cfg_we        = 1'b0;
    cfg_addr      = 2'd0;
    cfg_data      = 16'd0;
    tick();
    tick();
    check("reset en",       ingress_in_en, 1'b0);
    check("reset word",     ingress_in, 32'd0);
    check("reset busy",     busy, 1'b0);
    check("reset done",     done, 1'b0);
    check("reset sent_cnt", sent_cnt, 16'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // abort after the 4th pulse
    cfg_write(2'd0, 16'd10);
    cfg_write(2'd1, 16'd3);
    cfg_write(2'd2, 16'd0);
    experimenting = 1'b1;
    pulses = 0;
    cyc    = 0;
    while (pulses < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (ingress_in_en === 1'b1) pulses++;
    end
    check("abort reached4", pulses, 4);
    experimenting = 1'b0;
    tick();
    check("abort busy", busy, 1'b0);
    check("abort en",   ingress_in_en, 1'b0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ingress_in_en !== 1'b0) extra++;
    end
    check("abort extra_pulses", extra, 0);
    check("abort sent_cnt",     sent_cnt, 16'd4);
    check("abort done",         done, 1'b0);

    // reset while in WAIT
    cfg_write(2'd0, 16'd5);
    cfg_write(2'd1, 16'd4);
    cfg_write(2'd2, {12'd0, 2'd3, 2'd1});
    experimenting = 1'b1;
    cyc = 0;
    while (ingress_in_en !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    tick();
    check("rstmid busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid en",       ingress_in_en, 1'b0);
    check("rstmid word",     ingress_in, 32'd0);
    check("rstmid busy",     busy, 1'b0);
    check("rstmid done",     done, 1'b0);
    check("rstmid sent_cnt", sent_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    experimenting = 1'b0;
    tick();

    // default pkt_count=0: straight to DONE, held while experimenting stays high
    experimenting = 1'b1;
    tick();
    check("zero done", done, 1'b1);
    check("zero en",   ingress_in_en, 1'b0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ingress_in_en !== 1'b0 || done !== 1'b1) extra++;
    end
    check("zero hold", extra, 0);
    experimenting = 1'b0;
    tick();
    check("zero done_clear", done, 1'b0);

    // defaults interval=1, mode fixed, fixed_dest=0
    cfg_write(2'd0, 16'd2);
    experimenting = 1'b1;
    tick();
    check("dflt en0",   ingress_in_en, 1'b1);
    check("dflt dest0", ingress_in[29:28], 2'd0);
    tick();
    check("dflt en1",   ingress_in_en, 1'b1);
    check("dflt dest1", ingress_in[29:28], 2'd0);
    check("dflt seq1",  ingress_in[27:16], 12'd1);
    tick();
    check("dflt done",  done, 1'b1);
    experimenting = 1'b0;
    tick();

    // long run: sequence field wraps 4095 -> 0
    w = '{cnt:5000, intv:1, mode:2'd0, fdest:2'd0, spacing:1, dests:16'h0000, poke:1'b0};
    run_vec("wrap", w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/packet_gen.md
Name: packet_gen

Overview:
- Per-ingress synthetic traffic source sitting directly upstream of the ingress VOQ stage; drives its metadata input and enable.
- While an experiment runs, emits a configured number of 32-bit metadata words at a fixed spacing.
- Destination port in bits [29:28] is chosen by fixed, round-robin or pseudo-random policy.
- Software configures it through a small register port and reads progress counters.

Parameters:
SRC_ID, 0, 2-bit source ingress index placed in metadata [31:30]
META_WIDTH, 32, metadata width; only 32 supported
LFSR_SEED, 16'hACE1, reset/start value of destination LFSR; must be nonzero

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
experimenting  in  1  run enable; rising edge starts a run, low aborts
cfg_we  in  1  config write strobe
cfg_addr  in  2  config register select
cfg_data  in  16  config write data
global_time  in  16  shared free-running timestamp
ingress_in  out  32  metadata word to ingress stage
ingress_in_en  out  1  one-cycle valid for ingress_in
busy  out  1  run in progress
done  out  1  run completed, held until experimenting falls
sent_cnt  out  16  packets emitted in current/last run

Behaviour:
- Reset (reset=0, async) clears all state:
  - FSM=IDLE; outputs ingress_in=0, ingress_in_en=0, busy=0, done=0, sent_cnt=0.
  - Config registers: pkt_count=0, interval=1, mode=0, fixed_dest=0.
  - LFSR=LFSR_SEED, seq=0, rr pointer=0.
- Config registers, written only when cfg_we=1 and FSM=IDLE; writes in any other state are ignored:
  - addr0: pkt_count[15:0].
  - addr1: interval[15:0]; a value of 0 is treated as 1.
  - addr2: mode=cfg_data[1:0] (0 fixed, 1 round-robin, 2 random, 3 behaves as fixed); fixed_dest=cfg_data[3:2].
  - addr3: reserved, writes ignored.
- Metadata format: [31:30]=SRC_ID, [29:28]=dest, [27:16]=seq[11:0], [15:0]=global_time sampled in the emitting cycle.
- FSM states: IDLE, EMIT, WAIT, DONE.
- IDLE:
  - Detect rising edge (experimenting=1, registered previous value=0).
  - If pkt_count!=0: on that edge clear sent_cnt and seq, reload LFSR=LFSR_SEED, rr pointer=0, and go to EMIT.
  - If pkt_count=0: go straight to DONE.
- EMIT:
  - Lasts exactly one cycle; ingress_in_en=1 and ingress_in are valid only during this cycle.
  - First EMIT cycle is the cycle after the edge is sampled.
  - sent_cnt and seq increment at the end of the cycle; seq wraps modulo 4096.
  - Next state: if sent_cnt+1==pkt_count go to DONE; else if effective interval==1 stay in EMIT; else go to WAIT with a countdown of interval-2 remaining.
- WAIT: count down; at 0 go to EMIT. Consecutive ingress_in_en pulses are exactly max(interval,1) cycles apart.
- DONE: done=1, busy=0; go to IDLE when experimenting=0 (done clears on that transition).
- busy=1 in EMIT and WAIT.
- Abort: experimenting=0 in EMIT or WAIT sends the FSM to IDLE next cycle.
  - No EMIT occurs in the abort cycle's successor.
  - sent_cnt is retained until the next start.
- Destination selection:
  - Fixed: dest=fixed_dest.
  - Round-robin: dest=rr pointer, which increments by 1 mod 4 after each EMIT.
  - Random: dest=LFSR[1:0]. LFSR is a 16-bit Fibonacci, taps 16,14,13,11, and advances once per EMIT.
- No backpressure: ingress drops when its VOQ is full. The generator does not stall.
- Holding experimenting high after DONE does not restart a run; a new rising edge is required.

Test Plan:
- Reset mid-run (assert reset during WAIT) -> all outputs 0 immediately (async), FSM IDLE; config returns to defaults.
- pkt_count=4, interval=1, mode=fixed, fixed_dest=2, SRC_ID=1, experimenting rises -> 4 consecutive en pulses starting 1 cycle later. Words: [31:30]=1, [29:28]=2, seq 0..3. Then done=1, sent_cnt=4.
- pkt_count=3, interval=5, mode=round-robin -> pulses exactly 5 cycles apart, dests 0,1,2. Writing interval=1 while busy has no effect.
- pkt_count=8, mode=random -> dest sequence matches the reference LFSR model from seed 16'hACE1. A second run reproduces the identical sequence.
- pkt_count=10, interval=3; drop experimenting after the 4th pulse -> no further pulses, busy=0 next cycle, sent_cnt=4, done=0.
- pkt_count=5000, interval=1 -> seq field wraps 4095->0, sent_cnt=5000, done=1. Also pkt_count=0 -> no pulses, done=1 immediately.
